// File: rtl/reg_read_port.sv
// Read-side controller for the register bank's shared read bus: takes an address
// request, drives one register's output enable, samples the settled bus, returns it.
module reg_read_port #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic [NUM_REGS-1:0] reg_oe,
    input  logic [DATA_W-1:0]   bus_in,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [ADDR_W-1:0]   rsp_addr,
    output logic                rsp_err,
    output logic [7:0]          rd_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
    logic                err_q, err_d;
    logic [7:0]          count_q, count_d;
    logic                armed_q;
    logic                req_in_range;
    logic                oe_active;

    // armed_q keeps req_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_addr_q <= '0;
            err_q      <= 1'b0;
            count_q    <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rsp_addr_q <= rsp_addr_d;
            err_q      <= err_d;
            count_q    <= count_d;
            armed_q    <= 1'b1;
        end
    end

    assign req_in_range = ({1'b0, req_addr} < NUM_REGS_W);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rsp_addr_d = rsp_addr_q;
        err_d      = err_q;
        count_d    = count_q;
        req_ready  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = armed_q;
                if (req_valid && armed_q) begin
                    addr_d = req_addr;
                    if (req_in_range) begin
                        state_d = S_DRIVE;
                    end else begin
                        // Out-of-range requests never touch the bus.
                        data_d     = '0;
                        rsp_addr_d = req_addr;
                        err_d      = 1'b1;
                        state_d    = S_RESP;
                    end
                end
            end
            S_DRIVE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                data_d     = bus_in;
                rsp_addr_d = addr_q;
                err_d      = 1'b0;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    count_d = count_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign oe_active = (state_q == S_DRIVE) || (state_q == S_CAPTURE);

    // addr_q is known in range whenever oe_active, so at most one enable decodes true.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_oe
            assign reg_oe[gi] = oe_active && (addr_q == ADDR_W'(gi));
        end
    endgenerate

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = data_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_err   = err_q;
    assign rd_count  = count_q;

endmodule

// File: tb/tb_reg_read_port.sv
// Drives a four-register and a three-register instance side by side against a
// register-bank bus model and a per-transaction reference of the read protocol.
module tb_reg_read_port;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_addr;

    logic       req_ready_w [2];
    logic       rsp_valid_w [2];
    logic [7:0] rsp_data_w  [2];
    logic [1:0] rsp_addr_w  [2];
    logic       rsp_err_w   [2];
    logic [7:0] rd_count_w  [2];
    logic       rsp_ready   [2];
    logic [7:0] bus_w       [2];
    logic [3:0] oe_w        [2];
    logic [3:0] oe4;
    logic [2:0] oe3;

    logic [7:0] regs    [4];
    logic [3:0] oe_prev [2];
    logic [7:0] noise;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cnt_model [2];

    always #5 clk = ~clk;

    reg_read_port #(.NUM_REGS(4), .ADDR_W(2), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_w[0]), .req_addr(req_addr),
        .reg_oe(oe4), .bus_in(bus_w[0]),
        .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data_w[0]), .rsp_addr(rsp_addr_w[0]),
        .rsp_err(rsp_err_w[0]), .rd_count(rd_count_w[0])
    );

    reg_read_port #(.NUM_REGS(3), .ADDR_W(2), .DATA_W(8)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_w[1]), .req_addr(req_addr),
        .reg_oe(oe3), .bus_in(bus_w[1]),
        .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data_w[1]), .rsp_addr(rsp_addr_w[1]),
        .rsp_err(rsp_err_w[1]), .rd_count(rd_count_w[1])
    );

    assign oe_w[0] = oe4;
    assign oe_w[1] = {1'b0, oe3};

    // Bank model: the bus carries garbage until an enable has been held for a full cycle.
    always @(posedge clk) begin
        noise <= 8'($urandom);
        for (int d = 0; d < 2; d++) oe_prev[d] <= oe_w[d];
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            bus_w[d] = noise;
            if (oe_w[d] != 4'd0 && oe_w[d] == oe_prev[d]) begin
                for (int i = 0; i < 4; i++) begin
                    if (oe_w[d][i]) bus_w[d] = regs[i];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s.d%0d.oe", tag, d), 32'(oe_w[d]), 32'd0);
            chk($sformatf("%s.d%0d.rsp_valid", tag, d), 32'(rsp_valid_w[d]), 32'd0);
            chk($sformatf("%s.d%0d.rd_count", tag, d), 32'(rd_count_w[d]), 32'(cnt_model[d] % 256));
        end
    endtask

    // One read issued to both instances; each is tracked cycle by cycle after acceptance.
    task automatic do_read(input logic [1:0] a, input int stall);
        bit         drives [2];
        int         lat    [2];
        logic [7:0] exp_d  [2];
        bit         done   [2];
        bit         hsp    [2];
        int         left   [2];
        logic [3:0] exp_oe;
        int         k;
        for (int d = 0; d < 2; d++) begin
            drives[d] = (d == 0) ? 1'b1 : (a < 2'd3);
            lat[d]    = drives[d] ? 3 : 1;
            exp_d[d]  = drives[d] ? regs[a] : 8'h00;
            done[d]   = 1'b0;
            hsp[d]    = 1'b0;
            left[d]   = stall;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("rd%0d.d%0d.req_ready_pre", a, d), 32'(req_ready_w[d]), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        for (int d = 0; d < 2; d++) rsp_ready[d] = (stall == 0);
        @(posedge clk);
        #1;
        // Keep a bogus request pending while busy: it must be ignored.
        req_addr = 2'($urandom);
        k = 1;
        while (k <= 20 && !(done[0] && done[1])) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (done[d]) begin
                    chk($sformatf("rd%0d.d%0d.k%0d.post_oe", a, d, k), 32'(oe_w[d]), 32'd0);
                    chk($sformatf("rd%0d.d%0d.k%0d.post_valid", a, d, k), 32'(rsp_valid_w[d]), 32'd0);
                end else begin
                    exp_oe = (drives[d] && (k == 1 || k == 2)) ? (4'd1 << a) : 4'd0;
                    chk($sformatf("rd%0d.d%0d.k%0d.onehot0", a, d, k), 32'($onehot0(oe_w[d])), 32'd1);
                    chk($sformatf("rd%0d.d%0d.k%0d.oe", a, d, k), 32'(oe_w[d]), 32'(exp_oe));
                    chk($sformatf("rd%0d.d%0d.k%0d.req_ready", a, d, k), 32'(req_ready_w[d]), 32'd0);
                    chk($sformatf("rd%0d.d%0d.k%0d.rsp_valid", a, d, k), 32'(rsp_valid_w[d]), 32'(k >= lat[d]));
                    if (rsp_valid_w[d] === 1'b1) begin
                        chk($sformatf("rd%0d.d%0d.k%0d.data", a, d, k), 32'(rsp_data_w[d]), 32'(exp_d[d]));
                        chk($sformatf("rd%0d.d%0d.k%0d.addr", a, d, k), 32'(rsp_addr_w[d]), 32'(a));
                        chk($sformatf("rd%0d.d%0d.k%0d.err", a, d, k), 32'(rsp_err_w[d]), 32'(!drives[d]));
                        if (!rsp_ready[d]) begin
                            left[d]--;
                            if (left[d] <= 0) rsp_ready[d] = 1'b1;
                        end
                        if (rsp_ready[d]) hsp[d] = 1'b1;
                    end
                end
            end
            if (hsp[0] || hsp[1]) req_valid = 1'b0;
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (hsp[d]) begin
                    hsp[d]  = 1'b0;
                    done[d] = 1'b1;
                    cnt_model[d]++;
                    rsp_ready[d] = 1'b0;
                end
            end
            k++;
        end
        req_valid = 1'b0;
        for (int d = 0; d < 2; d++)
            chk($sformatf("rd%0d.d%0d.completed", a, d), 32'(done[d]), 32'd1);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("rd%0d.d%0d.req_ready_post", a, d), 32'(req_ready_w[d]), 32'd1);
        chk_idle_outputs($sformatf("rd%0d.after", a));
        $display("read addr=%0d stall=%0d data4=%02h data3=%02h err3=%0b count4=%0d count3=%0d",
                 a, stall, rsp_data_w[0], rsp_data_w[1], rsp_err_w[1], rd_count_w[0], rd_count_w[1]);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) cnt_model[d] = 0;
        chk_idle_outputs("rst_pulse");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 2'd0;
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) regs[i] = 8'($urandom);
        for (int d = 0; d < 2; d++) cnt_model[d] = 0;

        // Reset held with a request pending.
        #2;
        reset     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 2'd2;
        repeat (3) begin
            @(negedge clk);
            chk_idle_outputs("reset_hold");
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("reset_hold.d%0d.req_ready", d), 32'(req_ready_w[d]), 32'd0);
                chk($sformatf("reset_hold.d%0d.rsp_data", d), 32'(rsp_data_w[d]), 32'd0);
                chk($sformatf("reset_hold.d%0d.rsp_addr", d), 32'(rsp_addr_w[d]), 32'd0);
                chk($sformatf("reset_hold.d%0d.rsp_err", d), 32'(rsp_err_w[d]), 32'd0);
            end
        end
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready[0] = 1'b0;
        rsp_ready[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                chk($sformatf("release.d%0d.req_ready", d), 32'(req_ready_w[d]), 32'd1);
            chk_idle_outputs("release");
        end
        $display("reset check done");

        // Basic read, backpressure with a pending bogus request, out-of-range on the 3-reg instance.
        regs[2] = 8'hA5;
        do_read(2'd2, 0);
        regs[1] = 8'h3C;
        do_read(2'd1, 5);
        do_read(2'd3, 0);

        // Reset pulse while addr 0 is in CAPTURE.
        regs[0] = 8'h5A;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 2'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.capture_oe", 32'(oe_w[0]), 32'h1);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) cnt_model[d] = 0;
        chk_idle_outputs("midrst.asserted");
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk_idle_outputs("midrst.released");
        end
        $display("reset during capture done");
        do_read(2'd0, 0);

        // 256 back-to-back reads, bus value = addr * 0x11, counter wraps to zero.
        reset_pulse();
        for (int i = 0; i < 4; i++) regs[i] = 8'(i * 8'h11);
        for (int n = 0; n < 256; n++) do_read(2'(n % 4), 0);
        for (int d = 0; d < 2; d++)
            chk($sformatf("wrap.d%0d.rd_count", d), 32'(rd_count_w[d]), 32'd0);

        // Randomized reads with random register contents and stalls.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) regs[i] = 8'($urandom);
            do_read(2'($urandom_range(3)), int'($urandom_range(3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
